cvxif_offload_issuer: RTL
=========================

Name: cvxif_offload_issuer

Overview:
- Core-side CVXIF initiator that offloads custom instructions to an attached coprocessor (e.g. the ECC modular-arithmetic accelerator).
- Accepts one instruction and its operands from the core's issue stage and drives the CVXIF issue handshake.
- Generates the commit transaction, tracks outstanding transaction IDs, and returns coprocessor results to the core writeback port through a one-entry output buffer.

Parameters:
- XLEN, 64, operand/result width; must match cvxif_pkg.
- IdWidth, 3, transaction ID width; the outstanding bitmap has 2**IdWidth bits.
- MaxOutstanding, 4, maximum number of accepted-but-not-retired transactions; range 1..2**IdWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- off_valid_i  in  1  core offers an instruction
- off_ready_o  out  1  issuer can take the offer
- off_instr_i  in  32  instruction word
- off_rs1_i  in  XLEN  rs1 value
- off_rs2_i  in  XLEN  rs2 value
- off_id_i  in  IdWidth  core-assigned ID
- off_accepted_o  out  1  pulse: coprocessor accepted
- off_rejected_o  out  1  pulse: coprocessor rejected (core raises illegal-instruction)
- off_resp_id_o  out  IdWidth  ID for the accepted/rejected pulse
- cvxif_req_o  out  cvxif_req_t  request bundle to coprocessor
- cvxif_resp_i  in  cvxif_resp_t  response bundle from coprocessor
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  core consumes result
- wb_id_o  out  IdWidth  result ID
- wb_rd_o  out  5  destination register
- wb_data_o  out  XLEN  result data
- wb_we_o  out  1  register write enable
- wb_exc_o  out  1  coprocessor exception flag
- spurious_o  out  1  pulse: result ID was not outstanding

Behaviour:
- Clocking and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values:
  - Outputs: all valid/pulse outputs 0; data outputs 0; cvxif_req_o all zero.
  - Internal: bitmap cleared, outstanding count 0, FSM in IDLE.
- Tied-off fields: x_compressed_valid, x_mem_ready, x_mem_result_valid permanently 0.
- Issue FSM states: IDLE, ISSUE, COMMIT.
- IDLE:
  - off_ready_o = 1 iff count < MaxOutstanding and bitmap[off_id_i] == 0.
  - On off_valid_i & off_ready_o: register instr, rs1, rs2, id; rs_valid = 2'b11; mode = 0. Go to ISSUE.
- ISSUE:
  - x_issue_valid = 1, payload held stable until x_issue_ready.
  - On x_issue_ready with issue_resp.accept = 1: off_accepted_o pulses next cycle; set bitmap[id]; count + 1; go to COMMIT.
  - On x_issue_ready with accept = 0: off_rejected_o pulses next cycle; return to IDLE; bitmap unchanged.
- COMMIT:
  - x_commit_valid = 1 for exactly one cycle, with x_commit.id = id and commit_kill = 0.
  - Return to IDLE. Minimum issue-to-issue spacing is 3 cycles.
- Result path:
  - x_result_ready = !wb_valid_o | wb_ready_i.
  - On x_result_valid & x_result_ready:
    - If bitmap[id] = 1: load the output buffer next cycle (id, rd, data, we, exc); clear bitmap[id]; count - 1.
    - Else: spurious_o pulses, nothing is loaded.
  - wb_valid_o holds until wb_ready_i.
  - A buffered result is not lost when the buffer fills while the core stalls.
- Simultaneous events:
  - Accept (set) and a result retiring the same ID (clear) in one cycle: the set is applied to the ID being issued, the clear to the result ID. They are distinct IDs by construction.
  - Count update is the net of +1 and -1.
- Boundary conditions:
  - count == MaxOutstanding: off_ready_o = 0.
  - Reset mid-transaction: all in-flight state is discarded; no commit is emitted.

Optional Feature:
- Macro: CVXIF_OFFLOAD_KILL_EN.
- When defined, adds ports commit_go_i (in, 1) and flush_i (in, 1).
- COMMIT waits for commit_go_i, then emits commit with kill = 0.
- If flush_i is asserted in COMMIT, or together with commit_go_i, emit commit with kill = 1, clear bitmap[id], decrement count.
  - flush_i has priority over commit_go_i.
- A later result carrying that killed ID is reported as spurious and dropped.
- When undefined, commit is automatic as described in Behaviour and commit_kill is always 0.

Test Plan:
- Offload of instr 0x0000_707B (CUSTOM3), rs1 = 5, rs2 = 7, id = 2; coprocessor accepts and returns data 12, rd = 1, we = 1 -> off_accepted_o pulse with id 2, one commit with id 2 and kill 0, wb_data_o = 12, wb_rd_o = 1.
- Coprocessor deasserts x_issue_ready for 3 cycles -> x_issue_valid and payload stay stable all 3 cycles; exactly one handshake occurs.
- Coprocessor rejects (accept = 0) -> off_rejected_o pulse, no x_commit_valid, count stays 0.
- MaxOutstanding = 4 with IDs 0..3 accepted and no results -> off_ready_o = 0. Return the id 1 result -> off_ready_o = 1 again. Offering id 3 while it is outstanding -> off_ready_o = 0.
- Result with id 6 that is not outstanding -> spurious_o pulse, wb_valid_o stays 0.
- wb_ready_i held low with two results arriving -> first result is held, x_result_ready = 0 for the second; release wb_ready_i -> both are delivered in order.

Source files
------------

// File: rtl/cvxif_pkg.sv
// CV-X-IF type definitions shared by the core-side offload issuer and the coprocessor.
// Only the fields the issuer drives or consumes carry real meaning; the
// compressed and memory interfaces are present so the bundles match the protocol shape.
package cvxif_pkg;

  parameter int unsigned XLEN     = 64;
  parameter int unsigned XIdWidth = 3;
  parameter int unsigned XNumRs   = 2;

  typedef struct packed {
    logic [15:0]         instr;
    logic [1:0]          mode;
    logic [XIdWidth-1:0] id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0]                   instr;
    logic [1:0]                    mode;
    logic [XIdWidth-1:0]           id;
    logic [XNumRs-1:0][XLEN-1:0]   rs;
    logic [XNumRs-1:0]             rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [XIdWidth-1:0] id;
    logic                commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [XIdWidth-1:0] id;
    logic [XLEN-1:0]     data;
    logic [4:0]          rd;
    logic                we;
    logic                exc;
    logic [5:0]          exccode;
  } x_result_t;

  typedef struct packed {
    logic              x_compressed_valid;
    x_compressed_req_t x_compressed_req;
    logic              x_issue_valid;
    x_issue_req_t      x_issue_req;
    logic              x_commit_valid;
    x_commit_t         x_commit;
    logic              x_mem_ready;
    logic              x_mem_result_valid;
    logic              x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_compressed_ready;
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_mem_valid;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

endpackage

// File: rtl/cvxif_offload_issuer.sv
// Core-side CV-X-IF initiator. Takes one custom instruction plus operands from the
// core issue stage, runs the issue handshake, emits the commit, tracks outstanding
// IDs in a bitmap and returns coprocessor results through a one-entry writeback buffer.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   off_*                    offer from the core, accept/reject pulses back to it
//   cvxif_req_o/resp_i       CV-X-IF request/response bundles (cvxif_pkg)
//   wb_*                     buffered result towards core writeback (valid/ready)
//   spurious_o               pulse when a result arrives for an ID not outstanding
//   commit_go_i, flush_i     only with CVXIF_OFFLOAD_KILL_EN: core-controlled commit/kill
//
// Optional feature macro: CVXIF_OFFLOAD_KILL_EN. When undefined, commit follows
// acceptance automatically and is never killed.
module cvxif_offload_issuer #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   off_valid_i,
  output logic                   off_ready_o,
  input  logic [31:0]            off_instr_i,
  input  logic [XLEN-1:0]        off_rs1_i,
  input  logic [XLEN-1:0]        off_rs2_i,
  input  logic [IdWidth-1:0]     off_id_i,
  output logic                   off_accepted_o,
  output logic                   off_rejected_o,
  output logic [IdWidth-1:0]     off_resp_id_o,
  output cvxif_pkg::cvxif_req_t  cvxif_req_o,
  input  cvxif_pkg::cvxif_resp_t cvxif_resp_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [IdWidth-1:0]     wb_id_o,
  output logic [4:0]             wb_rd_o,
  output logic [XLEN-1:0]        wb_data_o,
  output logic                   wb_we_o,
  output logic                   wb_exc_o,
  output logic                   spurious_o
`ifdef CVXIF_OFFLOAD_KILL_EN
  ,
  input  logic                   commit_go_i,
  input  logic                   flush_i
`endif
);

  localparam int unsigned NumIds = 2 ** IdWidth;
  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

  state_e              state_q;
  logic [31:0]         instr_q;
  logic [XLEN-1:0]     rs1_q, rs2_q;
  logic [IdWidth-1:0]  id_q;
  logic [1:0]          rs_valid_q;
  logic [NumIds-1:0]   bitmap_q, bitmap_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                accepted_q, rejected_q;
  logic [IdWidth-1:0]  resp_id_q;
  logic                commit_valid_q, commit_kill_q;
  logic                live_q;
  logic                wb_valid_q, wb_we_q, wb_exc_q;
  logic [IdWidth-1:0]  wb_id_q;
  logic [4:0]          wb_rd_q;
  logic [XLEN-1:0]     wb_data_q;
  logic                spurious_q;

  logic               off_ready;
  logic               offer_fire;
  logic               issue_hs;
  logic               accept_evt;
  logic               result_ready;
  logic               res_fire;
  logic               res_hit;
  logic [IdWidth-1:0] res_id;
  logic               commit_set;
  logic               kill_set;
  logic               commit_leave;
  logic               flush_clr;

  assign res_id = cvxif_resp_i.x_result.id;

  // live_q keeps every request output (including x_result_ready) at zero while in reset.
  assign off_ready    = live_q && (state_q == StIdle) && (count_q < CntW'(MaxOutstanding)) &&
                        !bitmap_q[off_id_i];
  assign offer_fire   = off_valid_i && off_ready;
  assign issue_hs     = (state_q == StIssue) && cvxif_resp_i.x_issue_ready;
  assign accept_evt   = issue_hs && cvxif_resp_i.x_issue_resp.accept;
  assign result_ready = live_q && (!wb_valid_q || wb_ready_i);
  assign res_fire     = cvxif_resp_i.x_result_valid && result_ready;
  assign res_hit      = res_fire && bitmap_q[res_id];

`ifdef CVXIF_OFFLOAD_KILL_EN
  // Commit goes out the cycle after go/flush is seen; flush wins and marks it killed.
  assign commit_set   = (state_q == StCommit) && (commit_go_i || flush_i);
  assign kill_set     = (state_q == StCommit) && flush_i;
  assign commit_leave = commit_go_i || flush_i;
`else
  // Commit is raised on the accept edge so it is visible during the single COMMIT cycle.
  assign commit_set   = accept_evt;
  assign kill_set     = 1'b0;
  assign commit_leave = 1'b1;
`endif

  // A result may already have retired the ID being killed; never release it twice.
  assign flush_clr = kill_set && bitmap_q[id_q] && !(res_hit && (res_id == id_q));

  always_comb begin
    bitmap_d = bitmap_q;
    if (res_hit)    bitmap_d[res_id] = 1'b0;
    if (accept_evt) bitmap_d[id_q]   = 1'b1;
    if (flush_clr)  bitmap_d[id_q]   = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (accept_evt) count_d = count_d + CntW'(1);
    if (res_hit)    count_d = count_d - CntW'(1);
    if (flush_clr)  count_d = count_d - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      instr_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      id_q           <= '0;
      rs_valid_q     <= '0;
      bitmap_q       <= '0;
      count_q        <= '0;
      accepted_q     <= 1'b0;
      rejected_q     <= 1'b0;
      resp_id_q      <= '0;
      commit_valid_q <= 1'b0;
      commit_kill_q  <= 1'b0;
      live_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_id_q        <= '0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_we_q        <= 1'b0;
      wb_exc_q       <= 1'b0;
      spurious_q     <= 1'b0;
    end else begin
      live_q         <= 1'b1;
      bitmap_q       <= bitmap_d;
      count_q        <= count_d;
      accepted_q     <= 1'b0;
      rejected_q     <= 1'b0;
      commit_valid_q <= commit_set;
      commit_kill_q  <= kill_set;
      spurious_q     <= res_fire && !res_hit;

      unique case (state_q)
        StIdle: begin
          if (offer_fire) begin
            instr_q    <= off_instr_i;
            rs1_q      <= off_rs1_i;
            rs2_q      <= off_rs2_i;
            id_q       <= off_id_i;
            rs_valid_q <= 2'b11;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (issue_hs) begin
            resp_id_q <= id_q;
            if (cvxif_resp_i.x_issue_resp.accept) begin
              accepted_q <= 1'b1;
              state_q    <= StCommit;
            end else begin
              rejected_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
        end
        StCommit: begin
          if (commit_leave) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // result_ready guarantees the buffer is free or draining when a result lands.
      if (res_hit) begin
        wb_valid_q <= 1'b1;
        wb_id_q    <= res_id;
        wb_rd_q    <= cvxif_resp_i.x_result.rd;
        wb_data_q  <= cvxif_resp_i.x_result.data;
        wb_we_q    <= cvxif_resp_i.x_result.we;
        wb_exc_q   <= cvxif_resp_i.x_result.exc;
      end else if (wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cvxif_req_o                      = '0;
    cvxif_req_o.x_issue_valid        = (state_q == StIssue);
    cvxif_req_o.x_issue_req.instr    = instr_q;
    cvxif_req_o.x_issue_req.mode     = 2'b00;
    cvxif_req_o.x_issue_req.id       = id_q;
    cvxif_req_o.x_issue_req.rs[0]    = rs1_q;
    cvxif_req_o.x_issue_req.rs[1]    = rs2_q;
    cvxif_req_o.x_issue_req.rs_valid = rs_valid_q;
    cvxif_req_o.x_commit_valid       = commit_valid_q;
    cvxif_req_o.x_commit.id          = id_q;
    cvxif_req_o.x_commit.commit_kill = commit_kill_q;
    cvxif_req_o.x_result_ready       = result_ready;
  end

  assign off_ready_o    = off_ready;
  assign off_accepted_o = accepted_q;
  assign off_rejected_o = rejected_q;
  assign off_resp_id_o  = resp_id_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_id_o        = wb_id_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign wb_we_o        = wb_we_q;
  assign wb_exc_o       = wb_exc_q;
  assign spurious_o     = spurious_q;

  // Response fields this initiator has no use for.
  logic unused_resp;
  assign unused_resp = ^{cvxif_resp_i.x_compressed_ready, cvxif_resp_i.x_mem_valid,
                         cvxif_resp_i.x_issue_resp.writeback, cvxif_resp_i.x_issue_resp.dualwrite,
                         cvxif_resp_i.x_issue_resp.dualread, cvxif_resp_i.x_issue_resp.loadstore,
                         cvxif_resp_i.x_issue_resp.exc, cvxif_resp_i.x_result.exccode};

endmodule
